vga_sync_decoder: RTL and testbench
===================================

# vga_sync_decoder

Receive-side counterpart of the VGA timing generator: samples hsync/vsync/rgb on each pixel tick and rebuilds pixel coordinates and data-enable from the sync edges alone. It checks line and frame periods against the nominal 640x480 timing, reports lock, and produces a per-frame 16-bit pixel checksum. It sits on the VGA output pins, or on a loopback of them, as a self-check and capture front end.

## Interface
- H_DISP, 640, visible pixels per line
- H_FP, 16, horizontal front porch, in pixels
- H_SYNC, 96, hsync width, in pixels
- H_TOTAL, 800, pixels per line
- V_DISP, 480, visible lines per frame
- V_FP, 10, vertical front porch, in lines
- V_TOTAL, 525, lines per frame
- SYNC_POL, 1, asserted level of hsync and vsync
- sys_clk  in  1  system clock
- sys_rst  in  1  reset, synchronous, active-high
- p_tick  in  1  pixel-rate enable, one sys_clk wide
- hsync  in  1  horizontal sync
- vsync  in  1  vertical sync
- rgb  in  12  pixel colour
- pix_valid  out  1  one-cycle pulse per processed p_tick
- de  out  1  pixel is visible (x<H_DISP and y<V_DISP)
- x  out  10  recovered horizontal count
- y  out  10  recovered vertical count
- pix_rgb  out  12  rgb captured with x/y
- locked  out  1  timing verified stable
- h_err  out  1  one-cycle pulse on a bad line period
- v_err  out  1  one-cycle pulse on a bad frame period
- frame_done  out  1  one-cycle pulse when frame_sum updates
- frame_sum  out  16  checksum of the last completed frame

## Operation
- All sampling happens only on cycles with p_tick=1. Cycles without p_tick leave all state unchanged and hold pulses low.
- Sync history registers hold the previous hsync and vsync samples. An asserting edge is a sample equal to SYNC_POL whose previous sample was not.
- hcount:
  - On an hsync asserting edge: hcount <= H_DISP+H_FP.
  - Otherwise: hcount increments, and wraps from H_TOTAL-1 to 0.
- vcount:
  - On a vsync asserting edge: vcount <= V_DISP+V_FP.
  - Otherwise, when hcount wraps: vcount increments, and wraps from V_TOTAL-1 to 0.
  - A vsync edge takes priority over the wrap increment.
- Line period check:
  - tick_cnt counts p_ticks since the last hsync edge and saturates at 1023.
  - At each hsync edge after the first one following reset: if tick_cnt+1 ≠ H_TOTAL, pulse h_err.
  - tick_cnt then restarts.
- Frame period check:
  - line_cnt counts hsync edges since the last vsync edge and saturates at 1023.
  - If an hsync edge and a vsync edge occur on the same tick, that hsync edge counts toward the new frame.
  - At each vsync edge after the first one following reset: the frame is good if line_cnt = V_TOTAL and no h_err occurred since the previous vsync edge. Otherwise pulse v_err.
- Lock:
  - good_cnt (2-bit) increments on each good frame; locked asserts when good_cnt reaches 2.
  - Any h_err or v_err clears good_cnt and locked on the cycle the error pulses.
- Checksum:
  - acc <= acc + {4'b0, rgb} (mod 2^16) on each tick with de.
  - At each vsync edge, including the first: frame_sum <= acc (including the current pixel if de), acc <= 0, and frame_done pulses.
  - Lock state does not affect the checksum.
- de, x, y and pix_rgb reflect the counts and the rgb sample of the same tick, after that tick's counter update.

## Timing
- Latency: outputs and pulses are registered and valid on the cycle after the p_tick cycle. They hold until the next p_tick; pulses last exactly one sys_clk.
- Reset values:
  - All outputs are 0.
  - hcount, vcount, tick_cnt, line_cnt, acc and good_cnt are 0.
  - Sync history is ~SYNC_POL.
  - first-edge flags are set.
- Reset applied mid-frame restores all reset values on the next clock. No error is reported for the truncated frame; re-lock needs the full sequence again.
- Minimum time to lock after reset with ideal input: the third vsync edge, about 2 frames after the first edge.
- Sync widths are not checked; only asserting-edge spacing is checked.

## Test plan
- Ideal 640x480 stream, p_tick every 4th clock -> no h_err/v_err; locked rises one clock after the 3rd vsync edge.
- Constant rgb=12'h001 over full frames -> every frame_done after the first shows frame_sum=16'hB000 (307200 mod 65536).
- After lock, first visible tick after vsync -> pix_valid=1, x=0, y=0, de=1; tick at hcount 640 -> de=0, x=640.
- After lock, one line shortened to 799 ticks -> one h_err pulse, locked=0 the next clock; v_err at that frame's vsync; relock at the 2nd following good vsync edge.
- Frame with 524 lines -> v_err at the closing vsync, locked=0; frame_sum still updates with frame_done.
- sys_rst high for 1 clock mid-frame -> all outputs 0 next clock; the first vsync edge afterwards gives no v_err; lock returns after the 3rd vsync edge.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: rebuilds x/y/de from sync edges, checks line and
// frame periods, reports lock and produces a per-frame 16-bit pixel checksum.
module vga_sync_decoder #(
    parameter int H_DISP   = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_TOTAL  = 800,
    parameter int V_DISP   = 480,
    parameter int V_FP     = 10,
    parameter int V_TOTAL  = 525,
    parameter int SYNC_POL = 1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        p_tick,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] rgb,
    output logic        pix_valid,
    output logic        de,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic [11:0] pix_rgb,
    output logic        locked,
    output logic        h_err,
    output logic        v_err,
    output logic        frame_done,
    output logic [15:0] frame_sum
);
    localparam logic        POL      = 1'(SYNC_POL);
    localparam logic [9:0]  H_DISP_C = 10'(H_DISP);
    localparam logic [9:0]  H_START  = 10'(H_DISP + H_FP);
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [10:0] H_TOT_C  = 11'(H_TOTAL);
    localparam logic [9:0]  V_DISP_C = 10'(V_DISP);
    localparam logic [9:0]  V_START  = 10'(V_DISP + V_FP);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_TOT_C  = 10'(V_TOTAL);

    if (H_DISP + H_FP + H_SYNC > H_TOTAL || V_DISP + V_FP >= V_TOTAL) begin : g_bad_timing
        $error("vga_sync_decoder: inconsistent timing parameters");
    end

    logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    logic [9:0]  hcount_q, hcount_d, vcount_q, vcount_d;
    logic [9:0]  tick_cnt_q, tick_cnt_d, line_cnt_q, line_cnt_d;
    logic [15:0] acc_q, acc_d, frame_sum_q, frame_sum_d;
    logic [1:0]  good_cnt_q, good_cnt_d;
    logic        h_first_q, h_first_d, v_first_q, v_first_d;
    logic        herr_seen_q, herr_seen_d;
    logic        pix_valid_q, pix_valid_d, de_q, de_d;
    logic [11:0] pix_rgb_q, pix_rgb_d;
    logic        locked_q, locked_d, h_err_q, h_err_d, v_err_q, v_err_d;
    logic        frame_done_q, frame_done_d;

    logic        hs_edge, vs_edge, h_wrap, frame_good, good_frame;
    logic [15:0] acc_sum;

    always_comb begin
        hs_prev_d    = hs_prev_q;
        vs_prev_d    = vs_prev_q;
        hcount_d     = hcount_q;
        vcount_d     = vcount_q;
        tick_cnt_d   = tick_cnt_q;
        line_cnt_d   = line_cnt_q;
        acc_d        = acc_q;
        frame_sum_d  = frame_sum_q;
        good_cnt_d   = good_cnt_q;
        h_first_d    = h_first_q;
        v_first_d    = v_first_q;
        herr_seen_d  = herr_seen_q;
        pix_valid_d  = 1'b0;
        de_d         = de_q;
        pix_rgb_d    = pix_rgb_q;
        locked_d     = locked_q;
        h_err_d      = 1'b0;
        v_err_d      = 1'b0;
        frame_done_d = 1'b0;
        hs_edge      = p_tick && (hsync == POL) && (hs_prev_q != POL);
        vs_edge      = p_tick && (vsync == POL) && (vs_prev_q != POL);
        h_wrap       = !hs_edge && (hcount_q == H_LAST);
        frame_good   = 1'b0;
        good_frame   = 1'b0;
        acc_sum      = acc_q;

        if (p_tick) begin
            hs_prev_d   = hsync;
            vs_prev_d   = vsync;
            pix_valid_d = 1'b1;

            if (hs_edge)     hcount_d = H_START;
            else if (h_wrap) hcount_d = '0;
            else             hcount_d = hcount_q + 10'd1;

            if (vs_edge)     vcount_d = V_START;
            else if (h_wrap) vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;

            // Line period: ticks since the previous edge, inclusive of this one.
            if (hs_edge) begin
                tick_cnt_d = '0;
                h_first_d  = 1'b0;
                h_err_d    = !h_first_q && (({1'b0, tick_cnt_q} + 11'd1) != H_TOT_C);
            end else if (tick_cnt_q != 10'd1023) begin
                tick_cnt_d = tick_cnt_q + 10'd1;
            end

            frame_good = (line_cnt_q == V_TOT_C) && !herr_seen_q && !h_err_d;
            if (vs_edge) begin
                line_cnt_d  = hs_edge ? 10'd1 : 10'd0;
                herr_seen_d = 1'b0;
                v_first_d   = 1'b0;
                v_err_d     = !v_first_q && !frame_good;
                good_frame  = !v_first_q && frame_good;
            end else begin
                if (hs_edge && line_cnt_q != 10'd1023) line_cnt_d = line_cnt_q + 10'd1;
                herr_seen_d = herr_seen_q | h_err_d;
            end

            if (h_err_d || v_err_d)                  good_cnt_d = '0;
            else if (good_frame && good_cnt_q != 2'd2) good_cnt_d = good_cnt_q + 2'd1;
            locked_d = (good_cnt_d == 2'd2);

            de_d      = (hcount_d < H_DISP_C) && (vcount_d < V_DISP_C);
            pix_rgb_d = rgb;
            acc_sum   = acc_q + (de_d ? {4'b0, rgb} : 16'd0);
            if (vs_edge) begin
                frame_sum_d  = acc_sum;
                acc_d        = '0;
                frame_done_d = 1'b1;
            end else begin
                acc_d = acc_sum;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            hs_prev_q    <= ~POL;
            vs_prev_q    <= ~POL;
            hcount_q     <= '0;
            vcount_q     <= '0;
            tick_cnt_q   <= '0;
            line_cnt_q   <= '0;
            acc_q        <= '0;
            frame_sum_q  <= '0;
            good_cnt_q   <= '0;
            h_first_q    <= 1'b1;
            v_first_q    <= 1'b1;
            herr_seen_q  <= 1'b0;
            pix_valid_q  <= 1'b0;
            de_q         <= 1'b0;
            pix_rgb_q    <= '0;
            locked_q     <= 1'b0;
            h_err_q      <= 1'b0;
            v_err_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            hs_prev_q    <= hs_prev_d;
            vs_prev_q    <= vs_prev_d;
            hcount_q     <= hcount_d;
            vcount_q     <= vcount_d;
            tick_cnt_q   <= tick_cnt_d;
            line_cnt_q   <= line_cnt_d;
            acc_q        <= acc_d;
            frame_sum_q  <= frame_sum_d;
            good_cnt_q   <= good_cnt_d;
            h_first_q    <= h_first_d;
            v_first_q    <= v_first_d;
            herr_seen_q  <= herr_seen_d;
            pix_valid_q  <= pix_valid_d;
            de_q         <= de_d;
            pix_rgb_q    <= pix_rgb_d;
            locked_q     <= locked_d;
            h_err_q      <= h_err_d;
            v_err_q      <= v_err_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign pix_valid  = pix_valid_q;
    assign de         = de_q;
    assign x          = hcount_q;
    assign y          = vcount_q;
    assign pix_rgb    = pix_rgb_q;
    assign locked     = locked_q;
    assign h_err      = h_err_q;
    assign v_err      = v_err_q;
    assign frame_done = frame_done_q;
    assign frame_sum  = frame_sum_q;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a scaled-down 16x10 raster (8x6 visible)
// so that lock, error and relock sequences fit in a short run.
module tb_vga_sync_decoder;
    localparam int H_DISP = 8, H_FP = 2, H_SYNC = 3, H_TOTAL = 16;
    localparam int V_DISP = 6, V_FP = 1, V_TOTAL = 10, V_SYNC = 2;
    localparam int VS_LINE = V_DISP + V_FP;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        p_tick = 1'b0, hsync = 1'b0, vsync = 1'b0;
    logic [11:0] rgb = '0;
    logic        pix_valid, de, locked, h_err, v_err, frame_done;
    logic [9:0]  x, y;
    logic [11:0] pix_rgb;
    logic [15:0] frame_sum;

    int total = 0, bad = 0;
    int gen_h = 0, gen_v = 0, line_len = H_TOTAL, frame_len = V_TOTAL;
    logic [11:0] rgb_val = 12'h001;
    logic gen_vs_prev = 1'b0, vs_edge = 1'b0;
    int h_err_cnt = 0, v_err_cnt = 0;

    vga_sync_decoder #(
        .H_DISP(H_DISP), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_TOTAL(H_TOTAL),
        .V_DISP(V_DISP), .V_FP(V_FP), .V_TOTAL(V_TOTAL), .SYNC_POL(1)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .p_tick(p_tick), .hsync(hsync),
        .vsync(vsync), .rgb(rgb), .pix_valid(pix_valid), .de(de), .x(x), .y(y),
        .pix_rgb(pix_rgb), .locked(locked), .h_err(h_err), .v_err(v_err),
        .frame_done(frame_done), .frame_sum(frame_sum)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (h_err === 1'b1) h_err_cnt <= h_err_cnt + 1;
        if (v_err === 1'b1) v_err_cnt <= v_err_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One pixel tick every 4th clock; outputs are read 1 unit after the sampling edge.
    task automatic tick();
        logic hs_v, vs_v;
        repeat (3) @(posedge sys_clk);
        #1;
        hs_v = (gen_h >= H_DISP + H_FP) && (gen_h < H_DISP + H_FP + H_SYNC);
        vs_v = (gen_v >= VS_LINE) && (gen_v < VS_LINE + V_SYNC);
        vs_edge = vs_v && !gen_vs_prev;
        gen_vs_prev = vs_v;
        hsync = hs_v;
        vsync = vs_v;
        rgb = rgb_val;
        p_tick = 1'b1;
        @(posedge sys_clk);
        #1;
        p_tick = 1'b0;
        if (gen_h >= line_len - 1) begin
            gen_h = 0;
            gen_v = (gen_v >= frame_len - 1) ? 0 : gen_v + 1;
        end else begin
            gen_h = gen_h + 1;
        end
    endtask

    task automatic run_until(input int v, input int h);
        int guard = 0;
        while (!(gen_v == v && gen_h == h) && guard < 400) begin
            tick();
            guard++;
        end
        if (!(gen_v == v && gen_h == h)) begin
            total++; bad++;
            $display("FAIL run_until timeout: at (%0d,%0d) required (%0d,%0d)", gen_v, gen_h, v, h);
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        total++;
        if ({pix_valid, de, x, y, pix_rgb, locked, h_err, v_err, frame_done, frame_sum} !== '0)
            begin bad++; $display("FAIL reset_outputs: x=%0d y=%0d locked=%b sum=%h, all required 0", x, y, locked, frame_sum); end
    endtask

    task automatic test_lock();
        int edges = 0, guard = 0, he0 = h_err_cnt, ve0 = v_err_cnt;
        rgb_val = 12'h001;
        while (edges < 3 && guard < 2000) begin
            tick();
            guard++;
            if (vs_edge) begin
                edges++;
                total++;
                if (frame_done !== 1'b1) begin bad++; $display("FAIL lock_frame_done edge %0d: got %b need 1", edges, frame_done); end
                total++;
                if (frame_sum !== ((edges == 1) ? 16'h002F : 16'h0030))
                    begin bad++; $display("FAIL lock_frame_sum edge %0d: got %h", edges, frame_sum); end
                total++;
                if (locked !== (edges == 3)) begin bad++; $display("FAIL lock_locked edge %0d: got %b", edges, locked); end
            end
        end
        total++;
        if (edges != 3) begin bad++; $display("FAIL lock_timeout: saw %0d vsync edges need 3", edges); end
        @(negedge sys_clk); #1;
        total++;
        if (h_err_cnt != he0 || v_err_cnt != ve0)
            begin bad++; $display("FAIL lock_no_errors: h_err=%0d v_err=%0d need 0", h_err_cnt - he0, v_err_cnt - ve0); end
    endtask

    task automatic test_coords();
        run_until(0, 0);
        tick();
        total++;
        if ({pix_valid, de, x, y, pix_rgb} !== {1'b1, 1'b1, 10'd0, 10'd0, 12'h001})
            begin bad++; $display("FAIL first_pixel: pv=%b de=%b x=%0d y=%0d rgb=%h need 1 1 0 0 001", pix_valid, de, x, y, pix_rgb); end
        @(posedge sys_clk); #1;
        total++;
        if (pix_valid !== 1'b0) begin bad++; $display("FAIL pix_valid_width: got %b need 0", pix_valid); end
        run_until(0, 7);
        tick();
        total++;
        if (de !== 1'b1 || x !== 10'd7) begin bad++; $display("FAIL last_visible_x: de=%b x=%0d need 1 7", de, x); end
        rgb_val = 12'hA5C;
        tick();
        rgb_val = 12'h001;
        total++;
        if (de !== 1'b0 || x !== 10'd8 || pix_rgb !== 12'hA5C)
            begin bad++; $display("FAIL first_blank_x: de=%b x=%0d rgb=%h need 0 8 a5c", de, x, pix_rgb); end
        run_until(5, 7);
        tick();
        total++;
        if (de !== 1'b1 || y !== 10'd5) begin bad++; $display("FAIL last_visible_y: de=%b y=%0d need 1 5", de, y); end
        run_until(6, 0);
        tick();
        total++;
        if (de !== 1'b0 || y !== 10'd6 || x !== 10'd0)
            begin bad++; $display("FAIL first_blank_y: de=%b y=%0d x=%0d need 0 6 0", de, y, x); end
    endtask

    task automatic test_checksum();
        run_until(VS_LINE, 0);
        tick();
        rgb_val = 12'hFFF;
        run_until(VS_LINE, 0);
        tick();
        rgb_val = 12'h001;
        total++;
        if (frame_done !== 1'b1 || frame_sum !== 16'hFFD0)
            begin bad++; $display("FAIL sum_fff: done=%b sum=%h need 1 ffd0", frame_done, frame_sum); end
        run_until(VS_LINE, 0);
        tick();
        total++;
        if (frame_sum !== 16'h0030 || locked !== 1'b1)
            begin bad++; $display("FAIL sum_001: sum=%h locked=%b need 0030 1", frame_sum, locked); end
    endtask

    task automatic test_short_line();
        int he0 = h_err_cnt, ve0 = v_err_cnt;
        run_until(2, 0);
        total++;
        if (locked !== 1'b1) begin bad++; $display("FAIL short_line_pre_lock: got %b need 1", locked); end
        line_len = H_TOTAL - 1;
        run_until(3, 0);
        line_len = H_TOTAL;
        run_until(3, H_DISP + H_FP);
        tick();
        total++;
        if (h_err !== 1'b1 || locked !== 1'b0)
            begin bad++; $display("FAIL short_line_h_err: h_err=%b locked=%b need 1 0", h_err, locked); end
        run_until(VS_LINE, 0);
        tick();
        total++;
        if (v_err !== 1'b1 || frame_done !== 1'b1 || locked !== 1'b0)
            begin bad++; $display("FAIL short_line_v_err: v_err=%b done=%b locked=%b need 1 1 0", v_err, frame_done, locked); end
        run_until(VS_LINE, 0);
        tick();
        total++;
        if (v_err !== 1'b0 || locked !== 1'b0)
            begin bad++; $display("FAIL relock_first_good: v_err=%b locked=%b need 0 0", v_err, locked); end
        run_until(VS_LINE, 0);
        tick();
        total++;
        if (locked !== 1'b1) begin bad++; $display("FAIL relock_second_good: locked=%b need 1", locked); end
        @(negedge sys_clk); #1;
        total++;
        if (h_err_cnt - he0 != 1 || v_err_cnt - ve0 != 1)
            begin bad++; $display("FAIL short_line_pulse_count: h_err=%0d v_err=%0d need 1 1", h_err_cnt - he0, v_err_cnt - ve0); end
    endtask

    task automatic test_short_frame();
        int he0 = h_err_cnt, ve0 = v_err_cnt;
        run_until(VS_LINE, 0);
        tick();
        frame_len = V_TOTAL - 1;
        run_until(0, 0);
        frame_len = V_TOTAL;
        run_until(VS_LINE, 0);
        tick();
        total++;
        if (v_err !== 1'b1 || locked !== 1'b0 || frame_done !== 1'b1 || frame_sum !== 16'h0030)
            begin bad++; $display("FAIL short_frame: v_err=%b locked=%b done=%b sum=%h need 1 0 1 0030", v_err, locked, frame_done, frame_sum); end
        run_until(VS_LINE, 0);
        tick();
        run_until(VS_LINE, 0);
        tick();
        total++;
        if (locked !== 1'b1) begin bad++; $display("FAIL short_frame_relock: locked=%b need 1", locked); end
        @(negedge sys_clk); #1;
        total++;
        if (h_err_cnt != he0 || v_err_cnt - ve0 != 1)
            begin bad++; $display("FAIL short_frame_pulse_count: h_err=%0d v_err=%0d need 0 1", h_err_cnt - he0, v_err_cnt - ve0); end
    endtask

    task automatic test_reset_mid_frame();
        int edges = 0, guard = 0, he0, ve0;
        run_until(3, 2);
        total++;
        if (locked !== 1'b1 || x !== 10'd1) begin bad++; $display("FAIL mid_reset_pre: locked=%b x=%0d need 1 1", locked, x); end
        @(posedge sys_clk); #1 sys_rst = 1'b1;
        @(posedge sys_clk); #1 sys_rst = 1'b0;
        total++;
        if ({pix_valid, de, x, y, pix_rgb, locked, h_err, v_err, frame_done, frame_sum} !== '0)
            begin bad++; $display("FAIL mid_reset_outputs: x=%0d y=%0d locked=%b sum=%h, all required 0", x, y, locked, frame_sum); end
        he0 = h_err_cnt;
        ve0 = v_err_cnt;
        while (edges < 3 && guard < 2000) begin
            tick();
            guard++;
            if (vs_edge) begin
                edges++;
                total++;
                if (v_err !== 1'b0 || frame_done !== 1'b1 || locked !== (edges == 3))
                    begin bad++; $display("FAIL mid_reset_edge %0d: v_err=%b done=%b locked=%b", edges, v_err, frame_done, locked); end
            end
        end
        total++;
        if (edges != 3) begin bad++; $display("FAIL mid_reset_timeout: saw %0d vsync edges need 3", edges); end
        @(negedge sys_clk); #1;
        total++;
        if (h_err_cnt != he0 || v_err_cnt != ve0)
            begin bad++; $display("FAIL mid_reset_no_errors: h_err=%0d v_err=%0d need 0", h_err_cnt - he0, v_err_cnt - ve0); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_coords();
        test_checksum();
        test_short_line();
        test_short_frame();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
